neuron_layer_sequencer: RTL and testbench

- Time-multiplexes one signed multiply-accumulate datapath across all neurons of a fully-connected layer.
- Fetches inputs, weights and biases from synchronous-read memories, then applies ReLU.
- Emits one 8-bit activation per neuron over a valid/ready stream.
- Sits between the input feature buffer / weight ROMs and the next layer's input buffer; replaces a fully parallel combinational neuron array.

---
 rtl/nn_pkg.sv | 44 ++++
 rtl/nn_mac_unit.sv | 48 ++++
 rtl/neuron_layer_sequencer.sv | 155 +++++++++++++++
 tb/tb_neuron_layer_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared state type, activation constants and ReLU/clip function
//               for the neuron layer sequencer.
//               Macro NEURON_RELU_SAT_EN: saturate positive activations at
//               ACT_MAX instead of wrapping modulo 2**ACT_W.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int ACT_W     = 8;
    localparam int ACT_MAX   = 255;
    localparam int RELU_IN_W = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC   = 3'd1,
        DRAIN = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } nn_seq_state_t;

    // acc arrives sign-extended to RELU_IN_W so any accumulator width fits.
    function automatic logic [ACT_W-1:0] relu_clip(input logic [RELU_IN_W-1:0] acc);
        logic [ACT_W-1:0] act;
        if (acc[RELU_IN_W-1] || (acc == '0)) begin
            act = '0;
        end else begin
`ifdef NEURON_RELU_SAT_EN
            if (acc[RELU_IN_W-1:ACT_W] != '0) begin
                act = ACT_W'(ACT_MAX);
            end else begin
                act = acc[ACT_W-1:0];
            end
`else
            act = acc[ACT_W-1:0];
`endif
        end
        return act;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nn_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : nn_mac_unit
// Description : Signed multiply-accumulate: unsigned x times signed w, with a
//               bias-loading first step and plain accumulation afterwards.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_mac_unit #(
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    accum,
    input  logic [7:0]              x_data,
    input  logic signed [7:0]       w_data,
    input  logic signed [7:0]       b_data,
    output logic signed [ACC_W-1:0] sum
);

    localparam int PROD_W = 17;

    logic signed [8:0]        x_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc;

    // sum is the post-update value, so the sequencer can capture the final
    // neuron result in the same cycle the last product is added.
    always_comb begin
        x_ext    = signed'({1'b0, x_data});
        prod     = PROD_W'(x_ext) * PROD_W'(w_data);
        prod_ext = ACC_W'(prod);
        bias_ext = ACC_W'(b_data);
        sum      = load ? (bias_ext + prod_ext) : (acc + prod_ext);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load || accum) begin
            acc <= sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/neuron_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : neuron_layer_sequencer
// Description : Time-multiplexes one MAC across all neurons of a fully
//               connected layer and streams ReLU activations out.
//               Macro NEURON_RELU_SAT_EN selects saturating activations.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_layer_sequencer
    import nn_pkg::*;
#(
    parameter int INPUT_COUNT  = 4,
    parameter int NEURON_COUNT = 4,
    parameter int ACC_W        = 24,
    localparam int XA_W = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1,
    localparam int WA_W = (INPUT_COUNT * NEURON_COUNT > 1) ? $clog2(INPUT_COUNT * NEURON_COUNT) : 1,
    localparam int NA_W = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [XA_W-1:0]   x_addr,
    input  logic [7:0]        x_data,
    output logic [WA_W-1:0]   w_addr,
    input  logic [7:0]        w_data,
    output logic [NA_W-1:0]   b_addr,
    input  logic [7:0]        b_data,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [NA_W-1:0]   y_idx,
    output logic [ACT_W-1:0]  y_data
);

    generate
        if ((ACC_W < 17 + $clog2(INPUT_COUNT) + 1) || (ACC_W > RELU_IN_W)) begin : g_acc_w_check
            $error("neuron_layer_sequencer: ACC_W out of range for INPUT_COUNT");
        end
    endgenerate

    nn_seq_state_t           state;
    nn_seq_state_t           state_next;
    logic [XA_W-1:0]         i_cnt;
    logic [NA_W-1:0]         n_cnt;
    logic [WA_W-1:0]         w_cnt;
    logic                    last_i;
    logic                    last_n;
    logic                    mac_vld;
    logic                    mac_first;
    logic signed [ACC_W-1:0] mac_sum;

    assign last_i = (i_cnt == XA_W'(INPUT_COUNT - 1));
    assign last_n = (n_cnt == NA_W'(NEURON_COUNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MAC;
            MAC:     if (last_i) state_next = DRAIN;
            DRAIN:   state_next = OUT;
            OUT:     if (y_ready) state_next = last_n ? DONE : MAC;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        y_valid = (state == OUT);
    end

    // Counters double as the memory addresses, so they hold outside MAC.
    // w_cnt steps by one across the neuron boundary: n*INPUT_COUNT+i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt <= '0;
            n_cnt <= '0;
            w_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i_cnt <= '0;
                        n_cnt <= '0;
                        w_cnt <= '0;
                    end
                end
                MAC: begin
                    if (!last_i) begin
                        i_cnt <= i_cnt + XA_W'(1);
                        w_cnt <= w_cnt + WA_W'(1);
                    end
                end
                OUT: begin
                    if (y_ready && !last_n) begin
                        i_cnt <= '0;
                        n_cnt <= n_cnt + NA_W'(1);
                        w_cnt <= w_cnt + WA_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory data lags the address by one cycle; these flags follow it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_vld   <= 1'b0;
            mac_first <= 1'b0;
        end else begin
            mac_vld   <= (state == MAC);
            mac_first <= (state == MAC) && (i_cnt == '0);
        end
    end

    nn_mac_unit #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (mac_vld && mac_first),
        .accum  (mac_vld && !mac_first),
        .x_data (x_data),
        .w_data (w_data),
        .b_data (b_data),
        .sum    (mac_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_data <= '0;
            y_idx  <= '0;
        end else if (state == DRAIN) begin
            y_data <= relu_clip(RELU_IN_W'(mac_sum));
            y_idx  <= n_cnt;
        end
    end

    assign x_addr = i_cnt;
    assign w_addr = w_cnt;
    assign b_addr = n_cnt;

endmodule
`default_nettype wire

// File: tb/tb_neuron_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_layer_sequencer
// Description : Self-checking bench for neuron_layer_sequencer with a
//               spec-level reference model and synchronous-read memory models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_layer_sequencer;

    localparam int IC = 4;
    localparam int NC = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  x_addr;
    logic [7:0]  x_data;
    logic [2:0]  w_addr;
    logic [7:0]  w_data;
    logic [0:0]  b_addr;
    logic [7:0]  b_data;
    logic        y_valid;
    logic        y_ready;
    logic [0:0]  y_idx;
    logic [7:0]  y_data;

    logic [7:0]        x_mem [IC];
    logic signed [7:0] w_mem [IC*NC];
    logic signed [7:0] b_mem [NC];

    int n_checks;
    int n_fail;

    neuron_layer_sequencer #(
        .INPUT_COUNT  (IC),
        .NEURON_COUNT (NC),
        .ACC_W        (24)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .x_addr  (x_addr),
        .x_data  (x_data),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_idx   (y_idx),
        .y_data  (y_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        x_data <= x_mem[x_addr];
        w_data <= w_mem[w_addr];
        b_data <= b_mem[b_addr];
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact integer dot product plus bias, then ReLU and clip/wrap.
    function automatic int ref_act(input int n);
        longint acc;
        acc = longint'(b_mem[n]);
        for (int i = 0; i < IC; i++)
            acc += longint'(int'(x_mem[i])) * longint'(int'(w_mem[n*IC+i]));
        if (acc <= 0) return 0;
`ifdef NEURON_RELU_SAT_EN
        if (acc > 255) return 255;
        return int'(acc);
`else
        return int'(acc % 256);
`endif
    endfunction

    task automatic load_basic();
        for (int i = 0; i < IC; i++) begin
            x_mem[i]      = 8'(i + 1);
            w_mem[i]      = 8'sd1;
            w_mem[IC + i] = -8'sd1;
        end
        b_mem[0] = 8'sd0;
        b_mem[1] = 8'sd5;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_done"},    done,    0);
        check({tag, "_y_valid"}, y_valid, 0);
        check({tag, "_y_data"},  y_data,  0);
        check({tag, "_y_idx"},   y_idx,   0);
        check({tag, "_x_addr"},  x_addr,  0);
        check({tag, "_w_addr"},  w_addr,  0);
        check({tag, "_b_addr"},  b_addr,  0);
    endtask

    // mode 0: always ready, 1: random ready, 2: stall neuron 0 for 10 cycles.
    // glitch: pulse start during neuron 0 MAC and in the DONE cycle.
    task automatic run_pass(input int mode, input bit glitch);
        int k, since, stall, post, dones, cyc;
        bit seen, fin;
        logic [1:0] held_x;
        logic [2:0] held_w;
        int exp_y [NC];
        for (int n = 0; n < NC; n++) exp_y[n] = ref_act(n);
        k = 0; dones = 0; post = 0; stall = 0; seen = 0; fin = 0; cyc = 0;
        held_x = '0; held_w = '0;
        start = 1'b1;
        @(posedge clk); #1;
        since = 1;
        while (!fin && cyc < 400) begin
            start = 1'b0;
            if (mode == 1)                            y_ready = 1'($urandom_range(0, 1));
            else if (mode == 2 && k == 0 && stall < 10) y_ready = 1'b0;
            else                                      y_ready = 1'b1;
            if (y_valid && !seen) begin
                check("first_valid_latency", since, IC + 2);
                seen   = 1;
                held_x = x_addr;
                held_w = w_addr;
            end
            if (y_valid && mode == 2 && !y_ready) begin
                stall++;
                check("stall_y_data", y_data, exp_y[0]);
                check("stall_y_idx",  y_idx,  0);
                check("stall_x_addr", x_addr, held_x);
                check("stall_w_addr", w_addr, held_w);
            end
            if (y_valid && y_ready) begin
                if (k >= NC) begin
                    check("output_count", k + 1, NC);
                end else begin
                    check("y_idx",  y_idx,  k);
                    check("y_data", y_data, exp_y[k]);
                end
                k++;
                since = 0;
                seen  = 0;
            end
            if (done) begin
                dones++;
                check("done_count",     dones, 1);
                check("outputs_at_done", k,    NC);
                check("busy_in_done",   busy,  1);
                if (glitch) start = 1'b1;
            end else if (dones > 0) begin
                post++;
                check("busy_after_done",  busy,    0);
                check("valid_after_done", y_valid, 0);
                if (post == 3) fin = 1;
            end
            if (glitch && k == 0 && since == 2) start = 1'b1;
            @(posedge clk); #1;
            since++;
            cyc++;
        end
        check("pass_completed", fin, 1);
        start   = 1'b0;
        y_ready = 1'b1;
    endtask

    initial begin
        int cyc;
        clk = 1'b0; rst_n = 1'b0; start = 1'b0; y_ready = 1'b1;
        n_checks = 0; n_fail = 0;
        load_basic();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        load_basic();
        run_pass(0, 1'b0);

        for (int i = 0; i < IC*NC; i++) w_mem[i] = 8'sd127;
        for (int i = 0; i < IC; i++) x_mem[i] = 8'd255;
        b_mem[0] = 8'sd0; b_mem[1] = 8'sd0;
        run_pass(0, 1'b0);

        load_basic();
        run_pass(2, 1'b0);
        run_pass(0, 1'b1);

        // Abort during neuron 1 MAC.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(b_addr == 1'b1 && !y_valid && busy) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reached_neuron1_mac", (cyc < 100), 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            check("post_reset_y_valid", y_valid, 0);
            check("post_reset_busy",    busy,    0);
        end
        run_pass(0, 1'b0);

        repeat (15) begin
            for (int i = 0; i < IC; i++) x_mem[i] = 8'($urandom);
            for (int i = 0; i < IC*NC; i++) w_mem[i] = 8'($urandom);
            for (int n = 0; n < NC; n++) b_mem[n] = 8'($urandom);
            run_pass(1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
